// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered RV32I decode stage producing ALU control and operand fields
//   clk, rst_n                : clock, asynchronous active-low reset
//   flush                     : drop held and incoming instruction this cycle
//   in_valid/in_ready, instr  : upstream handshake and instruction word
//   out_valid/out_ready       : downstream handshake for the decoded payload
//   alu_ctrl, alu_src_imm, imm, rs1, rs2, rd, reg_write, mem_read, mem_write, branch, illegal
//                             : registered decoded payload
//   illegal_seen              : sticky flag, set when an illegal instruction is accepted
module alu_ctrl_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_ctrl,
    output logic              alu_src_imm,
    output logic [DATA_W-1:0] imm,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              illegal,
    output logic              illegal_seen
);
    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [3:0]        alu_ri;
    logic              f3_ok;
    logic [DATA_W-1:0] imm_i, imm_s, imm_b;
    logic [3:0]        ctrl_d;
    logic              src_d, rw_d, mr_d, mw_d, br_d, ill_d, accept;
    logic [DATA_W-1:0] imm_d;
    logic              out_valid_q, src_q, rw_q, mr_q, mw_q, br_q, ill_q, seen_q;
    logic [3:0]        ctrl_q;
    logic [DATA_W-1:0] imm_q;
    logic [4:0]        rs1_q, rs2_q, rd_q;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign imm_i  = {{(DATA_W-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{(DATA_W-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    // R-type and I-type share the funct3 -> ALU mapping; only R-type ADD honours funct7[5]
    assign alu_ri = f3 == 3'b111 ? 4'b0000 : f3 == 3'b110 ? 4'b0001 : f3 == 3'b011 ? 4'b0111 : 4'b0010;
    assign f3_ok  = f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b011;

    always_comb begin
        ctrl_d = 4'b0000;
        src_d  = 1'b0;
        rw_d   = 1'b0;
        mr_d   = 1'b0;
        mw_d   = 1'b0;
        br_d   = 1'b0;
        ill_d  = 1'b1;
        imm_d  = '0;
        case (opcode)
            7'b0110011: if (f3_ok) begin
                ctrl_d = (f3 == 3'b000 && instr[30]) ? 4'b0110 : alu_ri;
                rw_d   = 1'b1;
                ill_d  = 1'b0;
            end
            7'b0010011: if (f3_ok) begin
                ctrl_d = alu_ri;
                src_d  = 1'b1;
                rw_d   = 1'b1;
                imm_d  = imm_i;
                ill_d  = 1'b0;
            end
            7'b0000011: if (f3 == 3'b010) begin
                ctrl_d = 4'b0010;
                src_d  = 1'b1;
                rw_d   = 1'b1;
                mr_d   = 1'b1;
                imm_d  = imm_i;
                ill_d  = 1'b0;
            end
            7'b0100011: if (f3 == 3'b010) begin
                ctrl_d = 4'b0010;
                src_d  = 1'b1;
                mw_d   = 1'b1;
                imm_d  = imm_s;
                ill_d  = 1'b0;
            end
            7'b1100011: if (f3 == 3'b000) begin
                ctrl_d = 4'b0110;
                br_d   = 1'b1;
                imm_d  = imm_b;
                ill_d  = 1'b0;
            end
            default: ;
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= 4'b0000;
            src_q       <= 1'b0;
            imm_q       <= '0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            rw_q        <= 1'b0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
            seen_q      <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            ctrl_q      <= ctrl_d;
            src_q       <= src_d;
            imm_q       <= imm_d;
            rs1_q       <= instr[19:15];
            rs2_q       <= instr[24:20];
            rd_q        <= instr[11:7];
            rw_q        <= rw_d;
            mr_q        <= mr_d;
            mw_q        <= mw_d;
            br_q        <= br_d;
            ill_q       <= ill_d;
            seen_q      <= seen_q || ill_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign alu_ctrl     = ctrl_q;
    assign alu_src_imm  = src_q;
    assign imm          = imm_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign rd           = rd_q;
    assign reg_write    = rw_q;
    assign mem_read     = mr_q;
    assign mem_write    = mw_q;
    assign branch       = br_q;
    assign illegal      = ill_q;
    assign illegal_seen = seen_q;
endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb_alu_ctrl_stage: directed-vector self-checking bench for alu_ctrl_stage
module tb_alu_ctrl_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, imm;
    logic [3:0]  alu_ctrl;
    logic        alu_src_imm, reg_write, mem_read, mem_write, branch, illegal, illegal_seen;
    logic [4:0]  rs1, rs2, rd;
    int          n_chk = 0;
    int          n_fail = 0;

    alu_ctrl_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .illegal(illegal), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] w);
        in_valid = v;
        instr    = w;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("rst_seen", {31'd0, illegal_seen}, 32'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'h002081B3);
        step();
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_ctrl", {28'd0, alu_ctrl}, 32'b0010);
        check("add_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
        check("add_strb", {26'd0, reg_write, alu_src_imm, mem_read, mem_write, branch, illegal}, 32'b100000);
        offer(1'b1, 32'h402081B3);
        step();
        check("sub_ctrl", {28'd0, alu_ctrl}, 32'b0110);
        check("sub_valid", {31'd0, out_valid}, 32'd1);
        offer(1'b1, 32'hFFF00093);
        step();
        check("addi_ctrl", {28'd0, alu_ctrl}, 32'b0010);
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_strb", {26'd0, reg_write, alu_src_imm, mem_read, mem_write, branch, illegal}, 32'b110000);
        offer(1'b1, 32'h0020A423);
        step();
        check("sw_ctrl", {28'd0, alu_ctrl}, 32'b0010);
        check("sw_imm", imm, 32'h00000008);
        check("sw_strb", {26'd0, reg_write, alu_src_imm, mem_read, mem_write, branch, illegal}, 32'b010100);
        check("sw_regs", {22'd0, rs1, rs2}, {22'd0, 5'd1, 5'd2});
        offer(1'b1, 32'hFE208EE3);
        step();
        check("beq_ctrl", {28'd0, alu_ctrl}, 32'b0110);
        check("beq_imm", imm, 32'hFFFFFFFC);
        check("beq_strb", {26'd0, reg_write, alu_src_imm, mem_read, mem_write, branch, illegal}, 32'b000010);
        check("beq_valid", {31'd0, out_valid}, 32'd1);
        offer(1'b1, 32'h00432283);
        step();
        out_ready = 1'b0;
        offer(1'b1, 32'h002081B3);
        #1;
        check("stall_ready", {31'd0, in_ready}, 32'd0);
        check("lw_strb", {26'd0, reg_write, alu_src_imm, mem_read, mem_write, branch, illegal}, 32'b111000);
        check("lw_imm", imm, 32'h00000004);
        step();
        step();
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_imm", imm, 32'h00000004);
        check("stall_rd", {27'd0, rd}, 32'd5);
        check("stall_memrd", {31'd0, mem_read}, 32'd1);
        out_ready = 1'b1;
        #1;
        check("release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("release_memrd", {31'd0, mem_read}, 32'd0);
        check("release_rd", {27'd0, rd}, 32'd3);
        offer(1'b1, 32'h00000000);
        step();
        check("ill_flag", {31'd0, illegal}, 32'd1);
        check("ill_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("ill_strb", {27'd0, reg_write, alu_src_imm, mem_read, mem_write, branch}, 32'd0);
        check("ill_seen", {31'd0, illegal_seen}, 32'd1);
        offer(1'b1, 32'h002091B3);
        step();
        check("ill_r_f3", {31'd0, illegal}, 32'd1);
        check("ill_r_imm", imm, 32'd0);
        check("ill_r_rd", {27'd0, rd}, 32'd3);
        offer(1'b1, 32'hFFF00093);
        step();
        check("post_ill", {31'd0, illegal}, 32'd0);
        check("seen_sticky", {31'd0, illegal_seen}, 32'd1);
        offer(1'b1, 32'h402081B3);
        flush = 1'b1;
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_hold_imm", imm, 32'hFFFFFFFF);
        check("flush_hold_ctrl", {28'd0, alu_ctrl}, 32'b0010);
        offer(1'b1, 32'hFE208EE3);
        step();
        check("flush_idle_valid", {31'd0, out_valid}, 32'd0);
        check("flush_idle_br", {31'd0, branch}, 32'd0);
        flush = 1'b0;
        offer(1'b1, 32'h0020A423);
        step();
        check("sw2_valid", {31'd0, out_valid}, 32'd1);
        check("sw2_mw", {31'd0, mem_write}, 32'd1);
        offer(1'b0, 32'h0);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_imm", imm, 32'd0);
        check("arst_mw", {31'd0, mem_write}, 32'd0);
        check("arst_seen", {31'd0, illegal_seen}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'h002081B3);
        step();
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_ctrl", {28'd0, alu_ctrl}, 32'b0010);
        offer(1'b0, 32'h0);
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered decode stage that turns a 32-bit RV32I instruction word into the 4-bit ALU control code plus operand and control fields consumed by the execute stage. It sits between the fetch/register-read side and the ALU, and is the producer end of the ALU's control interface. It holds one instruction in an output register with a valid/ready handshake, and supports stall (backpressure) and flush.

## Interface
- DATA_W, 32, instruction and immediate width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  discard held and incoming instruction this cycle
- in_valid  input  1  instr is valid
- in_ready  output  1  stage accepts instr this cycle
- instr  input  DATA_W  instruction word
- out_valid  output  1  decoded payload valid
- out_ready  input  1  execute stage consumes payload
- alu_ctrl  output  4  ALU operation code
- alu_src_imm  output  1  operand b = imm (1) or rs2 data (0)
- imm  output  DATA_W  sign-extended immediate
- rs1, rs2, rd  output  5 each  register indices
- reg_write, mem_read, mem_write, branch  output  1 each  control strobes
- illegal  output  1  instruction not supported
- illegal_seen  output  1  sticky; set on any accepted illegal instruction

## Operation
- ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 set-less-than (unsigned), 1100 NOR (never generated here).
- Decode by opcode instr[6:0], funct3 instr[14:12], funct7[5] instr[30]:
  - 0110011 R-type: f3 000 -> ADD (f7[5]=0) / SUB (f7[5]=1); 111 AND; 110 OR; 011 SLTU -> 0111. reg_write=1, alu_src_imm=0. Other f3 illegal.
  - 0010011 I-type: 000 ADDI -> 0010; 111 ANDI -> 0000; 110 ORI -> 0001; 011 SLTIU -> 0111. reg_write=1, alu_src_imm=1, I-imm. Other f3 illegal.
  - 0000011 LW (f3 010): ADD, I-imm, mem_read=1, reg_write=1, alu_src_imm=1.
  - 0100011 SW (f3 010): ADD, S-imm, mem_write=1, alu_src_imm=1.
  - 1100011 BEQ (f3 000): SUB, B-imm, branch=1, alu_src_imm=0.
  - Anything else: illegal=1, alu_ctrl=0000, all strobes 0, imm=0; rs1/rs2/rd still carry raw fields.
- Immediates sign-extended from instr[31]: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
- rs1/rs2/rd always instr[19:15]/[24:20]/[11:7].
- Handshake: in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready & !flush.
- Register update priority: flush > accept > drain.
  - flush: out_valid<=0; payload unchanged.
  - accept: payload <= decode(instr); out_valid<=1.
  - else if out_ready: out_valid<=0.
- illegal_seen <= 1 on accept of an illegal instruction; cleared only by reset.

## Timing
- Reset (async on rst_n low): out_valid=0, alu_ctrl=0000, imm=0, rs1=rs2=rd=0, all strobes 0, illegal=0, illegal_seen=0. in_ready=1 during and after reset.
- Latency 1 cycle: instr accepted at edge N appears at outputs after edge N with out_valid=1.
- Throughput 1/cycle with out_ready held high; accept and drain in the same cycle replace the payload with no bubble.
- While out_valid=1 and out_ready=0: in_ready=0; payload and out_valid held stable.
- Flush with out_valid=0 and in_valid=1: instruction dropped; out_valid stays 0.
- rst_n deassertion mid-stream: first accept possible on the first edge after release.

## Test plan
- Reset then ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_ctrl=0010, rd=3, rs1=1, rs2=2, reg_write=1, alu_src_imm=0.
- SUB 0x402081B3, ADDI x1,x0,-1 (0xFFF00093), SW x2,8(x1) (0x0020A423), BEQ x1,x2,-4 (0xFE208EE3) back-to-back -> alu_ctrl 0110/0010/0010/0110; imm 0xFFFFFFFF, 0x00000008, 0xFFFFFFFC; one output per cycle, no bubbles.
- Hold out_ready=0 with LW x5,4(x6) (0x00432283) held, then new instr offered -> in_ready=0, payload frozen (mem_read=1, imm=4); release out_ready -> new instr accepted same cycle.
- Illegal 0x00000000 -> illegal=1, alu_ctrl=0000, strobes 0, illegal_seen=1 and remains 1 after later valid instructions.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0; incoming instr not presented.
- rst_n pulled low while out_valid=1 -> outputs immediately at reset values, before any clock edge.
